// File: rtl/exec_controller.sv
// Execution sequencer for the single-cycle RISC-V core: free run, debounced single
// step, PC breakpoint and ECALL/EBREAK halt, plus a retired-instruction counter.
module exec_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_addr,
  input  logic [31:0]      inst,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halt_hit
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  function automatic logic is_stop_inst(input logic [31:0] word);
    return (word == 32'h0000_0073) || (word == 32'h0010_0073);
  endfunction

  logic             run_meta_r;
  logic             run_sync_r;
  logic             step_meta_r;
  logic             step_sync_r;
  logic             step_level_r;
  logic             step_level_d_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             skip_r;
  logic [CNT_W-1:0] retired_r;
  logic             halt_hit_r;
  state_e           state_r;
  state_e           state_next_s;
  logic             step_pulse_s;
  logic             stop_inst_s;
  logic             bp_hit_s;
  logic             cpu_en_s;

  assign step_pulse_s = step_level_r & ~step_level_d_r;
  assign stop_inst_s  = is_stop_inst(inst);
  assign bp_hit_s     = bp_en && (pc_addr == bp_addr) && !skip_r;

  // Two-flop synchronizers for the asynchronous button and switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_r  <= 1'b0;
      run_sync_r  <= 1'b0;
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
    end else begin
      run_meta_r  <= run_sw;
      run_sync_r  <= run_meta_r;
      step_meta_r <= step_btn;
      step_sync_r <= step_meta_r;
    end
  end

  // Step debouncer: a return to the accepted level restarts the stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_level_r   <= 1'b0;
      step_level_d_r <= 1'b0;
      deb_cnt_r      <= DEB_ZERO;
    end else begin
      step_level_d_r <= step_level_r;
      if (step_sync_r == step_level_r) begin
        deb_cnt_r <= DEB_ZERO;
      end else if (deb_cnt_r == DEB_MAX) begin
        step_level_r <= step_sync_r;
        deb_cnt_r    <= DEB_ZERO;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_HALT: begin
        if (step_pulse_s)    state_next_s = ST_STEP;
        else if (run_sync_r) state_next_s = ST_RUN;
        else                 state_next_s = ST_HALT;
      end
      ST_RUN: begin
        if (!run_sync_r)                   state_next_s = ST_HALT;
        else if (stop_inst_s || bp_hit_s)  state_next_s = ST_BREAK;
        else                               state_next_s = ST_RUN;
      end
      ST_STEP: state_next_s = ST_HALT;
      ST_BREAK: begin
        if (step_pulse_s)     state_next_s = ST_STEP;
        else if (!run_sync_r) state_next_s = ST_HALT;
        else                  state_next_s = ST_BREAK;
      end
      default: state_next_s = ST_HALT;
    endcase
  end

  // Commit enable; a step always commits, even on ECALL/EBREAK
  always_comb begin
    cpu_en_s = 1'b0;
    case (state_r)
      ST_STEP: cpu_en_s = 1'b1;
      ST_RUN:  cpu_en_s = !bp_hit_s && !stop_inst_s;
      default: cpu_en_s = 1'b0;
    endcase
  end

  // State register, breakpoint skip flag, retire counter and break indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HALT;
      skip_r     <= 1'b0;
      retired_r  <= {CNT_W{1'b0}};
      halt_hit_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      halt_hit_r <= (state_next_s == ST_BREAK);
      // Resuming onto the breakpoint PC must execute it rather than re-break
      if (((state_r == ST_HALT) || (state_r == ST_BREAK)) &&
          ((state_next_s == ST_RUN) || (state_next_s == ST_STEP))) begin
        skip_r <= 1'b1;
      end else if (cpu_en_s) begin
        skip_r <= 1'b0;
      end else begin
        skip_r <= skip_r;
      end
      if (cpu_en_s) retired_r <= retired_r + CNT_W'(1);
      else          retired_r <= retired_r;
    end
  end

  assign cpu_en   = cpu_en_s;
  assign state    = state_r;
  assign retired  = retired_r;
  assign halt_hit = halt_hit_r;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: per-cycle vector table with a scoreboard queue, plus
// hand-written long-run / asynchronous-reset sequence.
module tb_exec_controller;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NEVER  = 32'hFFFF_FFF0;
  localparam logic [1:0]  H = 2'd0, R = 2'd1, S = 2'd2, B = 2'd3;
  localparam int          F_CYC = 32'h1238;

  logic        clk, rst_n, step_btn, run_sw, bp_en;
  logic [31:0] bp_addr, pc_addr, inst;
  logic        cpu_en, halt_hit, cpu_en_w, halt_hit_w;
  logic [1:0]  state, state_w;
  logic [15:0] retired;
  logic [3:0]  retired_w;

  exec_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .run_sw(run_sw), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_addr(pc_addr), .inst(inst), .cpu_en(cpu_en),
    .state(state), .retired(retired), .halt_hit(halt_hit));

  exec_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .run_sw(run_sw), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_addr(pc_addr), .inst(inst), .cpu_en(cpu_en_w),
    .state(state_w), .retired(retired_w), .halt_hit(halt_hit_w));

  typedef struct {
    logic        rst;
    logic        run;
    logic        btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] stop_pc;
    logic [31:0] loop_end;
    logic        en;
    logic [1:0]  st;
    logic [15:0] ret;
  } vec_t;

  typedef struct {
    int          idx;
    logic        en;
    logic [1:0]  st;
    logic [15:0] ret;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] pc;
  logic        cur_bp_en, pend_rst;
  logic [31:0] cur_bp_addr, cur_stop, cur_loop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
  endtask

  // Scoreboard: compare each queued expectation at the falling edge of its cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cpu_en",    e.idx, {31'd0, cpu_en},    {31'd0, e.en});
      chk("state",     e.idx, {30'd0, state},     {30'd0, e.st});
      chk("retired",   e.idx, {16'd0, retired},   {16'd0, e.ret});
      chk("retired_w", e.idx, {28'd0, retired_w}, {28'd0, e.ret[3:0]});
      chk("halt_hit",  e.idx, {31'd0, halt_hit},  {31'd0, (e.st == B)});
    end
  end

  task automatic start(input logic be, input logic [31:0] ba, input logic [31:0] sp, input logic [31:0] le);
    cur_bp_en = be; cur_bp_addr = ba; cur_stop = sp; cur_loop = le; pend_rst = 1'b1;
  endtask

  task automatic addn(input int n, input logic run, input logic btn, input logic en,
                      input logic [1:0] st, input int ret);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = pend_rst; v.run = run; v.btn = btn; v.bp_en = cur_bp_en;
      v.bp_addr = cur_bp_addr; v.stop_pc = cur_stop; v.loop_end = cur_loop;
      v.en = en; v.st = st; v.ret = 16'(ret);
      vecs.push_back(v);
      pend_rst = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = 32'h0; pc = 32'h0; pc_addr = 32'h0; inst = NOP;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = 32'h0; pc = 32'h0; pc_addr = 32'h0; inst = NOP;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",    -1, {30'd0, state},    32'd0);
    chk("reset_cpu_en",   -1, {31'd0, cpu_en},   32'd0);
    chk("reset_retired",  -1, {16'd0, retired},  32'd0);
    chk("reset_halt_hit", -1, {31'd0, halt_hit}, 32'd0);

    // Free run; narrow counter wraps at 16 commits; switch off still commits in last RUN cycle
    start(1'b0, 32'h0, NEVER, NEVER);
    addn(3, 1'b1, 1'b0, 1'b0, H, 0);
    for (int k = 0; k < 17; k++) addn(1, 1'b1, 1'b0, 1'b1, R, k);
    addn(1, 1'b0, 1'b0, 1'b1, R, 17);
    addn(1, 1'b0, 1'b0, 1'b1, R, 18);
    addn(1, 1'b0, 1'b0, 1'b1, R, 19);
    addn(2, 1'b0, 1'b0, 1'b0, H, 20);
    // Bouncing button gives exactly one step, release gives none
    start(1'b0, 32'h0, NEVER, NEVER);
    addn(1, 1'b0, 1'b1, 1'b0, H, 0);
    addn(1, 1'b0, 1'b0, 1'b0, H, 0);
    addn(7, 1'b0, 1'b1, 1'b0, H, 0);
    addn(1, 1'b0, 1'b1, 1'b1, S, 0);
    addn(2, 1'b0, 1'b1, 1'b0, H, 1);
    addn(9, 1'b0, 1'b0, 1'b0, H, 1);
    // Breakpoint at 0x10, held run stays in BREAK, step commits 0x10
    start(1'b1, 32'h10, NEVER, NEVER);
    addn(3, 1'b1, 1'b0, 1'b0, H, 0);
    for (int k = 0; k < 4; k++) addn(1, 1'b1, 1'b0, 1'b1, R, k);
    addn(1, 1'b1, 1'b0, 1'b0, R, 4);
    addn(1, 1'b1, 1'b0, 1'b0, B, 4);
    addn(5, 1'b1, 1'b1, 1'b0, B, 4);
    addn(2, 1'b0, 1'b1, 1'b0, B, 4);
    addn(1, 1'b0, 1'b1, 1'b1, S, 4);
    addn(3, 1'b0, 1'b0, 1'b0, H, 5);
    // EBREAK at 0x20: breaks, re-breaks after run toggle, step executes past it
    start(1'b0, 32'h0, 32'h20, NEVER);
    addn(3, 1'b1, 1'b0, 1'b0, H, 0);
    for (int k = 0; k < 8; k++) addn(1, 1'b1, 1'b0, 1'b1, R, k);
    addn(1, 1'b1, 1'b0, 1'b0, R, 8);
    addn(3, 1'b0, 1'b0, 1'b0, B, 8);
    addn(3, 1'b1, 1'b0, 1'b0, H, 8);
    addn(1, 1'b1, 1'b0, 1'b0, R, 8);
    addn(1, 1'b1, 1'b0, 1'b0, B, 8);
    addn(5, 1'b1, 1'b1, 1'b0, B, 8);
    addn(2, 1'b0, 1'b1, 1'b0, B, 8);
    addn(1, 1'b0, 1'b1, 1'b1, S, 8);
    addn(3, 1'b0, 1'b0, 1'b0, H, 9);
    // Breakpoint at the halted PC: first pass commits, loop back breaks
    start(1'b1, 32'h0, NEVER, 32'hC);
    addn(3, 1'b1, 1'b0, 1'b0, H, 0);
    for (int k = 0; k < 4; k++) addn(1, 1'b1, 1'b0, 1'b1, R, k);
    addn(1, 1'b1, 1'b0, 1'b0, R, 4);
    addn(2, 1'b1, 1'b0, 1'b0, B, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      @(posedge clk); #1;
      run_sw = v.run; step_btn = v.btn; bp_en = v.bp_en; bp_addr = v.bp_addr;
      pc_addr = pc; inst = (pc == v.stop_pc) ? EBREAK : NOP;
      exp_q.push_back('{i, v.en, v.st, v.ret});
      if (v.en) pc = (pc == v.loop_end) ? 32'h0 : pc + 32'd4;
    end
    @(posedge clk); @(negedge clk);
    chk("queue_drained", -1, exp_q.size(), 32'd0);

    // Long run to 0x1234 commits, then asynchronous reset between edges
    do_reset();
    for (int i = 0; i < F_CYC; i++) begin
      @(posedge clk); #1;
      run_sw = 1'b1; pc_addr = pc; inst = NOP; pc = pc + 32'd4;
    end
    @(negedge clk);
    chk("long_retired",   -2, {16'd0, retired},   32'h1234);
    chk("long_retired_w", -2, {28'd0, retired_w}, 32'h4);
    chk("long_state",     -2, {30'd0, state},     {30'd0, R});
    #2 rst_n = 1'b0;
    #1;
    chk("async_retired",  -2, {16'd0, retired},   32'd0);
    chk("async_state",    -2, {30'd0, state},     32'd0);
    chk("async_cpu_en",   -2, {31'd0, cpu_en},    32'd0);
    chk("async_halt_hit", -2, {31'd0, halt_hit},  32'd0);
    chk("async_retired_w",-2, {28'd0, retired_w}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
